// File: rtl/hwag_capture_mc.sv
// Multi-channel crank/cam capture front-end: synchroniser, glitch filter,
// edge detection and period / missing-tooth / stall measurement per channel.
module hwag_capture_mc #(
  parameter int CH        = 2,
  parameter int FW        = 16,
  parameter int TW        = 24,
  parameter int GAP_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    vr_in,
  input  logic [CH-1:0]    filt_ena,
  input  logic [CH-1:0]    cap_ena,
  input  logic [CH-1:0]    edge_sel,
  input  logic [CH*FW-1:0] flt_val,
  output logic [CH-1:0]    filtered,
  output logic [CH-1:0]    edge_rise,
  output logic [CH-1:0]    edge_fall,
  output logic [CH-1:0]    cap_valid,
  output logic [CH*TW-1:0] period,
  output logic [CH-1:0]    gap,
  output logic [CH-1:0]    stall
);

  localparam int CW = TW + GAP_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } cap_state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          sync_a;
    logic          sync_b;
    logic          flt_q;
    logic          flt_prev;
    logic          rise_q;
    logic          fall_q;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] thr;
    logic          rise_c;
    logic          fall_c;
    logic          act;

    cap_state_e    state_q;
    cap_state_e    state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] period_q;
    logic [TW-1:0] period_d;
    logic [TW-1:0] prev_period_q;
    logic [TW-1:0] prev_period_d;
    logic          prev_ok_q;
    logic          prev_ok_d;
    logic          cap_q;
    logic          cap_d;
    logic          gap_q;
    logic          gap_d;
    logic          stall_q;
    logic          stall_d;
    logic [CW-1:0] cur_wide;
    logic [CW-1:0] ref_wide;

    assign thr = flt_val[i*FW +: FW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
      end else begin
        sync_a <= vr_in[i];
        sync_b <= sync_a;
      end
    end

    // A new level is adopted only after it has persisted thr+1 samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flt_q <= 1'b0;
        cnt_q <= '0;
      end else if (!filt_ena[i]) begin
        flt_q <= sync_b;
        cnt_q <= '0;
      end else if (sync_b == flt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == thr) begin
        flt_q <= sync_b;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign rise_c = flt_q & ~flt_prev;
    assign fall_c = ~flt_q & flt_prev;
    assign act    = edge_sel[i] ? fall_c : rise_c;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flt_prev <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        flt_prev <= flt_q;
        rise_q   <= rise_c;
        fall_q   <= fall_c;
      end
    end

    // Gap test is done one bit wider so the shifted reference cannot overflow.
    assign cur_wide = CW'(timer_q);
    assign ref_wide = CW'(prev_period_q) << GAP_SHIFT;

    always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      period_d      = period_q;
      prev_period_d = prev_period_q;
      prev_ok_d     = prev_ok_q;
      cap_d         = 1'b0;
      gap_d         = 1'b0;
      stall_d       = stall_q;
      if (!cap_ena[i]) begin
        state_d   = ST_IDLE;
        timer_d   = '0;
        stall_d   = 1'b0;
        prev_ok_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d   = ST_ARM;
            timer_d   = '0;
            prev_ok_d = 1'b0;
          end
          ST_ARM: begin
            prev_ok_d = 1'b0;
            if (act) begin
              timer_d = {{(TW-1){1'b0}}, 1'b1};
              stall_d = 1'b0;
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (act) begin
              period_d      = timer_q;
              cap_d         = 1'b1;
              gap_d         = prev_ok_q && (cur_wide > ref_wide);
              prev_period_d = timer_q;
              prev_ok_d     = 1'b1;
              timer_d       = {{(TW-1){1'b0}}, 1'b1};
            end else if (timer_q == {TW{1'b1}}) begin
              stall_d   = 1'b1;
              prev_ok_d = 1'b0;
              state_d   = ST_ARM;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q       <= ST_IDLE;
        timer_q       <= '0;
        period_q      <= '0;
        prev_period_q <= '0;
        prev_ok_q     <= 1'b0;
        cap_q         <= 1'b0;
        gap_q         <= 1'b0;
        stall_q       <= 1'b0;
      end else begin
        state_q       <= state_d;
        timer_q       <= timer_d;
        period_q      <= period_d;
        prev_period_q <= prev_period_d;
        prev_ok_q     <= prev_ok_d;
        cap_q         <= cap_d;
        gap_q         <= gap_d;
        stall_q       <= stall_d;
      end
    end

    assign filtered[i]         = flt_q;
    assign edge_rise[i]        = rise_q;
    assign edge_fall[i]        = fall_q;
    assign cap_valid[i]        = cap_q;
    assign period[i*TW +: TW]  = period_q;
    assign gap[i]              = gap_q;
    assign stall[i]            = stall_q;
  end

endmodule

// File: tb/tb_hwag_capture_mc.sv
// Bench for hwag_capture_mc: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hwag_capture_mc;

  localparam int CH = 2;
  localparam int FW = 16;
  localparam int TW = 8;
  localparam int GS = 1;

  logic             clk;
  logic             rst;
  logic [CH-1:0]    vr_in;
  logic [CH-1:0]    filt_ena;
  logic [CH-1:0]    cap_ena;
  logic [CH-1:0]    edge_sel;
  logic [CH*FW-1:0] flt_val;
  logic [CH-1:0]    filtered;
  logic [CH-1:0]    edge_rise;
  logic [CH-1:0]    edge_fall;
  logic [CH-1:0]    cap_valid;
  logic [CH*TW-1:0] period;
  logic [CH-1:0]    gap;
  logic [CH-1:0]    stall;

  int checks = 0;
  int errors = 0;

  hwag_capture_mc #(.CH(CH), .FW(FW), .TW(TW), .GAP_SHIFT(GS)) dut (
    .clk(clk), .rst(rst), .vr_in(vr_in), .filt_ena(filt_ena), .cap_ena(cap_ena),
    .edge_sel(edge_sel), .flt_val(flt_val), .filtered(filtered),
    .edge_rise(edge_rise), .edge_fall(edge_fall), .cap_valid(cap_valid),
    .period(period), .gap(gap), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model: filter as a run-length rule, timer as time since last active edge.
  bit vh1[CH], vh2[CH], mf[CH], mfp[CH], mrise[CH], mfall[CH];
  bit hp[CH], mcap[CH], mgap[CH], mstall[CH];
  int mrun[CH], mode[CH], last[CH], prevp[CH], mper[CH];
  int ncyc;
  bit fin, act;
  int el;
  logic [CH-1:0]    e_f, e_r, e_fl, e_c, e_g, e_s;
  logic [CH*TW-1:0] e_p;

  always @(posedge clk) begin
    if (rst) begin
      ncyc = 0;
      for (int c = 0; c < CH; c++) begin
        vh1[c] = 0; vh2[c] = 0; mf[c] = 0; mfp[c] = 0; mrise[c] = 0; mfall[c] = 0;
        hp[c] = 0; mcap[c] = 0; mgap[c] = 0; mstall[c] = 0;
        mrun[c] = 0; mode[c] = 0; last[c] = 0; prevp[c] = 0; mper[c] = 0;
      end
    end else begin
      ncyc++;
      for (int c = 0; c < CH; c++) begin
        fin = vh2[c];
        vh2[c] = vh1[c];
        vh1[c] = vr_in[c];
        mrise[c] = mf[c] & ~mfp[c];
        mfall[c] = ~mf[c] & mfp[c];
        mfp[c] = mf[c];
        if (!filt_ena[c]) begin
          mf[c] = fin; mrun[c] = 0;
        end else if (fin == mf[c]) begin
          mrun[c] = 0;
        end else begin
          mrun[c]++;
          if (mrun[c] > int'(flt_val[c*FW +: FW])) begin
            mf[c] = fin; mrun[c] = 0;
          end
        end
        act = edge_sel[c] ? mfall[c] : mrise[c];
        mcap[c] = 0;
        mgap[c] = 0;
        if (!cap_ena[c]) begin
          mode[c] = 0; mstall[c] = 0; hp[c] = 0;
        end else if (mode[c] == 0) begin
          mode[c] = 1;
        end else if (mode[c] == 1) begin
          hp[c] = 0;
          if (act) begin
            mode[c] = 2; last[c] = ncyc; mstall[c] = 0;
          end
        end else begin
          el = ncyc - last[c];
          if (act) begin
            mper[c] = el; mcap[c] = 1;
            mgap[c] = hp[c] && (el > (prevp[c] << GS));
            prevp[c] = el; hp[c] = 1; last[c] = ncyc;
          end else if (el == (1 << TW) - 1) begin
            mstall[c] = 1; hp[c] = 0; mode[c] = 1;
          end
        end
      end
    end
    #1;
    for (int c = 0; c < CH; c++) begin
      e_f[c] = mf[c]; e_r[c] = mrise[c]; e_fl[c] = mfall[c];
      e_c[c] = mcap[c]; e_g[c] = mgap[c]; e_s[c] = mstall[c];
      e_p[c*TW +: TW] = TW'(mper[c]);
    end
    checkOutput("model filtered", 64'(filtered), 64'(e_f));
    checkOutput("model edge_rise", 64'(edge_rise), 64'(e_r));
    checkOutput("model edge_fall", 64'(edge_fall), 64'(e_fl));
    checkOutput("model cap_valid", 64'(cap_valid), 64'(e_c));
    checkOutput("model period", 64'(period), 64'(e_p));
    checkOutput("model gap", 64'(gap), 64'(e_g));
    checkOutput("model stall", 64'(stall), 64'(e_s));
  end

  // Capture log of DUT events for the directed scenario checks.
  int lp0[$], lg0[$], lp1[$], lg1[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (cap_valid[0]) begin lp0.push_back(int'(period[TW-1:0])); lg0.push_back(int'(gap[0])); end
      if (cap_valid[1]) begin lp1.push_back(int'(period[2*TW-1:TW])); lg1.push_back(int'(gap[1])); end
    end
  end

  task automatic clearLogs();
    lp0.delete(); lg0.delete(); lp1.delete(); lg1.delete();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int ch, input bit lvl);
    @(negedge clk);
    vr_in[ch] = lvl;
  endtask

  task automatic toothTrain(input int ch, input int count, input int spacing, input int hi);
    for (int t = 0; t < count; t++)
      for (int c = 0; c < spacing; c++)
        applyStimulus(ch, c < hi);
  endtask

  initial begin
    #200000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] watchdog expired");
  end

  int first_f, first_r, rcnt, fcnt, hcnt, rise_at, stall_at;
  int exp_p[6] = '{10, 10, 10, 30, 10, 10};
  int exp_g[6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; vr_in = '0; filt_ena = '0; cap_ena = '0; edge_sel = '0; flt_val = '0;
    waitCycles(4);
    checkOutput("reset period", 64'(period), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);
    rst = 1'b0;
    waitCycles(5);

    $display("[TB] bypass latency, ch0");
    first_f = -1; first_r = -1; rcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (filtered[0] && first_f < 0) first_f = k - 1;
        if (edge_rise[0]) begin rcnt++; if (first_r < 0) first_r = k - 1; end
      end
      vr_in[0] = 1'b1;
    end
    checkOutput("bypass filtered latency", 64'(first_f), 64'd2);
    checkOutput("bypass rise latency", 64'(first_r), 64'd3);
    checkOutput("bypass rise count", 64'(rcnt), 64'd1);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1'b0);

    $display("[TB] glitch filter flt_val=4");
    filt_ena[0] = 1'b1; flt_val[FW-1:0] = 16'd4;
    waitCycles(3);
    hcnt = 0; rcnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (filtered[0]) hcnt++;
        if (edge_rise[0]) rcnt++;
      end
      vr_in[0] = (k < 3);
    end
    checkOutput("glitch filtered high cycles", 64'(hcnt), 64'd0);
    checkOutput("glitch rise count", 64'(rcnt), 64'd0);
    first_f = -1; rcnt = 0; fcnt = 0;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (filtered[0] && first_f < 0) first_f = k - 1;
        if (edge_rise[0]) rcnt++;
        if (edge_fall[0]) fcnt++;
      end
      vr_in[0] = (k < 6);
    end
    checkOutput("pulse filtered latency", 64'(first_f), 64'd6);
    checkOutput("pulse rise count", 64'(rcnt), 64'd1);
    checkOutput("pulse fall count", 64'(fcnt), 64'd1);
    filt_ena[0] = 1'b0; flt_val[FW-1:0] = 16'd0;

    $display("[TB] square wave period 20");
    cap_ena[0] = 1'b1; edge_sel[0] = 1'b0;
    waitCycles(4);
    clearLogs();
    toothTrain(0, 4, 20, 10);
    waitCycles(6);
    checkOutput("sq20 capture count", 64'(lp0.size()), 64'd3);
    foreach (lp0[j]) begin
      checkOutput("sq20 period", 64'(lp0[j]), 64'd20);
      checkOutput("sq20 gap", 64'(lg0[j]), 64'd0);
    end
    checkOutput("model pin period 20", 64'(mper[0]), 64'd20);

    $display("[TB] missing tooth wheel");
    cap_ena[0] = 1'b0; waitCycles(2); cap_ena[0] = 1'b1; waitCycles(3);
    clearLogs();
    toothTrain(0, 4, 10, 5);
    for (int k = 0; k < 20; k++) applyStimulus(0, 1'b0);
    toothTrain(0, 3, 10, 5);
    waitCycles(6);
    checkOutput("wheel capture count", 64'(lp0.size()), 64'd6);
    for (int j = 0; j < 6 && j < lp0.size(); j++) begin
      checkOutput("wheel period", 64'(lp0[j]), 64'(exp_p[j]));
      checkOutput("wheel gap", 64'(lg0[j]), 64'(exp_g[j]));
    end
    checkOutput("model pin gap prev", 64'(prevp[0]), 64'd10);

    $display("[TB] stall at timer saturation");
    cap_ena[0] = 1'b0; waitCycles(2); cap_ena[0] = 1'b1; waitCycles(3);
    clearLogs();
    rise_at = -1; stall_at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (edge_rise[0] && rise_at < 0) rise_at = k;
      if (stall[0] && stall_at < 0) stall_at = k;
      vr_in[0] = (k < 5);
      if (stall_at >= 0) break;
    end
    checkOutput("stall delay after arm", 64'(stall_at - rise_at), 64'd255);
    checkOutput("model pin stall", 64'(mstall[0]), 64'd1);
    checkOutput("stall no capture", 64'(lp0.size()), 64'd0);
    toothTrain(0, 2, 15, 5);
    waitCycles(6);
    checkOutput("post stall cleared", 64'(stall[0]), 64'd0);
    checkOutput("post stall capture count", 64'(lp0.size()), 64'd1);
    if (lp0.size() > 0) begin
      checkOutput("post stall period", 64'(lp0[0]), 64'd15);
      checkOutput("post stall gap", 64'(lg0[0]), 64'd0);
    end

    $display("[TB] two channels, disable on edge");
    cap_ena = '0; waitCycles(2);
    edge_sel[1] = 1'b1; filt_ena[1] = 1'b1; flt_val[2*FW-1:FW] = 16'd2;
    cap_ena = 2'b11; waitCycles(3);
    clearLogs();
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      vr_in[0] = ((t % 12) < 6);
      vr_in[1] = ((t % 17) < 8);
      if (t == 63) cap_ena[0] = 1'b0;
    end
    waitCycles(6);
    checkOutput("ch0 capture count", 64'(lp0.size()), 64'd4);
    foreach (lp0[j]) checkOutput("ch0 period", 64'(lp0[j]), 64'd12);
    checkOutput("ch1 capture count", 64'(lp1.size()), 64'd6);
    foreach (lp1[j]) begin
      checkOutput("ch1 period", 64'(lp1[j]), 64'd17);
      checkOutput("ch1 gap", 64'(lg1[j]), 64'd0);
    end
    checkOutput("ch0 period held", 64'(period[TW-1:0]), 64'd12);
    checkOutput("ch1 period", 64'(period[2*TW-1:TW]), 64'd17);

    $display("[TB] async reset mid-capture");
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      vr_in[1] = ((t % 17) < 8);
    end
    @(negedge clk);
    vr_in = '0;
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset period", 64'(period), 64'd0);
    checkOutput("async reset filtered", 64'(filtered), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clearLogs();
    waitCycles(10);
    checkOutput("post reset no capture", 64'(lp1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
